// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy tracking for long-latency results plus the
// register-file write-port arbiter. Optional long-unit starvation guard: define RF_ARB_STARVE_EN.
module rf_scoreboard #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rs1_used,
    input  logic        issue_rs2_used,
    input  logic        issue_long,
    output logic        issue_stall,
    input  logic        pipe_wb_valid,
    input  logic [4:0]  pipe_wb_rd,
    input  logic [31:0] pipe_wb_data,
    output logic        pipe_wb_ready,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        reg_write,
    output logic [4:0]  reg_regid,
    output logic [31:0] reg_writedata,
    output logic [31:0] busy_vec
);
    // Handshake rule: a transfer happens on a rising edge where valid & ready are
    // both high; the long unit holds lu_rd/lu_data stable while lu_valid & !lu_ready.

    logic [31:0] busy;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        starve_grant;
    logic        pipe_grant;
    logic        lu_grant;

    assign busy_vec = busy;

    // Hazard check uses only registered busy bits; reset forces it low.
    always_comb begin
        issue_stall = 1'b0;
        if (issue_valid && !rst) begin
            issue_stall = (issue_rs1_used && busy[issue_rs1]) ||
                          (issue_rs2_used && busy[issue_rs2]) ||
                          busy[issue_rd];
        end
    end

`ifdef RF_ARB_STARVE_EN
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;

    assign starve_grant = !rst && lu_valid && (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (lu_valid && lu_ready) begin
            starve_cnt <= '0;
        end else if (lu_valid) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`else
    assign starve_grant = 1'b0;
`endif

    assign pipe_wb_ready = !starve_grant;
    assign lu_ready      = starve_grant || !pipe_wb_valid;
    assign pipe_grant    = pipe_wb_valid && pipe_wb_ready;
    assign lu_grant      = lu_valid && lu_ready;

    // Writes to x0 still complete their handshake but never reach the file.
    always_comb begin
        reg_write     = 1'b0;
        reg_regid     = '0;
        reg_writedata = '0;
        if (pipe_grant) begin
            reg_write     = (pipe_wb_rd != 5'd0);
            reg_regid     = pipe_wb_rd;
            reg_writedata = pipe_wb_data;
        end else if (lu_grant) begin
            reg_write     = (lu_rd != 5'd0);
            reg_regid     = lu_rd;
            reg_writedata = lu_data;
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && !issue_stall && issue_long) begin
            set_mask = 32'd1 << issue_rd;
        end
        if (lu_grant) begin
            clr_mask = 32'd1 << lu_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

endmodule
